// File: rtl/aes_inv_key_expand_128_if.sv
// ---------------------------------------------------------------------------
// aes_inv_key_expand_128_if
//   Handshake bundle between the backward AES-128 key schedule and its
//   consumer (the decryption datapath).
//   slave  : key-schedule side (takes ld/key_in/rk_ready, drives rk stream)
//   master : consumer/controller side
//   Signals:
//     ld        start request, sampled only while the schedule is idle
//     key_in    round-10 key, word 0 in [127:96]
//     rk        current round key, same word order as key_in
//     rk_round  round index of rk (10..0)
//     rk_valid  rk/rk_round valid
//     rk_ready  consumer accepts rk (transfer = rk_valid && rk_ready)
//     busy      sequence in progress
//     done      one-cycle pulse after round 0 has been transferred
// ---------------------------------------------------------------------------
interface aes_inv_key_expand_128_if;
    logic         ld;
    logic [127:0] key_in;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    modport slave (
        input  ld, key_in, rk_ready,
        output rk, rk_round, rk_valid, busy, done
    );

    modport master (
        output ld, key_in, rk_ready,
        input  rk, rk_round, rk_valid, busy, done
    );
endinterface

// File: rtl/aes_inv_key_expand_128.sv
// ---------------------------------------------------------------------------
// aes_inv_key_expand_128
//   Backward AES-128 key schedule. Loads the round-10 key and walks the
//   schedule back to round 0, presenting one round key per valid/ready beat,
//   so the decryption datapath never needs all 11 keys stored at once.
//   Ports:
//     clk   clock, all state on rising edge
//     rst   asynchronous reset, active low
//     bus   aes_inv_key_expand_128_if.slave (ld, key_in, rk, rk_round,
//           rk_valid, rk_ready, busy, done)
//   Build option:
//     AES_INV_KEY_EQINV_EN  when defined, rk for rounds 9..1 is presented in
//                           InvMixColumns form (equivalent inverse cipher);
//                           rounds 10 and 0 stay raw. The internal recursion
//                           always runs on raw keys.
//   Also contains aes_sbox, the combinational forward S-box used for SubWord.
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    // Entry 0x00 is the most significant byte, so entry a sits at index ~a.
    localparam logic [255:0][7:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y_o = TBL[~a_i];
endmodule

module aes_inv_key_expand_128 (
    input  logic                      clk,
    input  logic                      rst,
    aes_inv_key_expand_128_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_q;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic         valid_q, busy_q, done_q;

    // ---- previous round key, combinational from key_q ----
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot, sub;
    logic [7:0]  rcon;
    logic [127:0] prev;
    logic         xfer;

    assign {k0, k1, k2, k3} = key_q;
    assign p3  = k3 ^ k2;
    assign p2  = k2 ^ k1;
    assign p1  = k1 ^ k0;
    assign rot = {p3[23:0], p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a_i(rot[31-8*g -: 8]), .y_o(sub[31-8*g -: 8]));
    end

    // Rcon of the round being stepped away from; 0 and 11..15 never occur.
    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign p0   = k0 ^ sub ^ {rcon, 24'h0};
    assign prev = {p0, p1, p2, p3};
    assign xfer = valid_q & bus.rk_ready;

`ifdef AES_INV_KEY_EQINV_EN
    logic [127:0] rk_q;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one 32-bit column (byte 0 in [31:24]).
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a, x2, x4, x8;
        logic [3:0][7:0] m9, mb, md, me;
        for (int i = 0; i < 4; i++) begin
            a  = c[31-8*i -: 8];
            x2 = xt(a);
            x4 = xt(x2);
            x8 = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] k);
        return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
                inv_mix_col(k[63:32]),  inv_mix_col(k[31:0])};
    endfunction
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef AES_INV_KEY_EQINV_EN
            rk_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ld) begin
                        key_q   <= bus.key_in;
                        round_q <= 4'd10;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef AES_INV_KEY_EQINV_EN
                        rk_q    <= bus.key_in;
`endif
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (round_q != 4'd0) begin
                            key_q   <= prev;
                            round_q <= round_q - 4'd1;
`ifdef AES_INV_KEY_EQINV_EN
                            // Round 0 is the only step that lands on a raw key.
                            rk_q    <= (round_q == 4'd1) ? prev : inv_mix(prev);
`endif
                        end else begin
                            // rk/rk_round keep the round-0 key after the sequence.
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AES_INV_KEY_EQINV_EN
    assign bus.rk = rk_q;
`else
    assign bus.rk = key_q;
`endif
    assign bus.rk_round = round_q;
    assign bus.rk_valid = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_expand_128.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_expand_128
//   Self-checking bench for aes_inv_key_expand_128. The reference model runs
//   the ordinary forward AES-128 key expansion from a round-0 key (S-box built
//   from GF(2^8) inversion + affine map), then the DUT is loaded with the
//   resulting round-10 key and must stream rounds 10..0 back.
//   Honours AES_INV_KEY_EQINV_EN for the expected key format.
// ---------------------------------------------------------------------------
module tb_aes_inv_key_expand_128;
    logic clk;
    logic rst;

    aes_inv_key_expand_128_if bus ();

    aes_inv_key_expand_128 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]   sb [256];
    logic [127:0] ref_rk [11];
    logic [127:0] got_rk [11];
    int           cyc_cnt;

    typedef struct {
        int           rnd;
        logic [127:0] raw;
    } vec_t;
    vec_t tbl [4];

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtm(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xtm(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Forward FIPS-197 expansion: fills ref_rk[0..10] from the cipher key.
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtm(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [7:0] coef(input int d);
        case (d)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    function automatic logic [127:0] inv_mix_m(input logic [127:0] k);
        logic [127:0] o = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(k[127-32*c-8*j -: 8], coef((j - i + 4) % 4));
                o[127-32*c-8*i -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] exp_key(input logic [127:0] raw, input int r);
`ifdef AES_INV_KEY_EQINV_EN
        if (r >= 1 && r <= 9) return inv_mix_m(raw);
`endif
        return raw;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_key(input logic [127:0] k);
        bus.ld     = 1'b1;
        bus.key_in = k;
        step();
        bus.ld     = 1'b0;
    endtask

    // Called in the cycle after an accepted ld; consumes rounds 10..0 and
    // returns in the done cycle. Expected keys come from ref_rk.
    task automatic drain(input int stall_r, input int stall_n, input int glitch_r, input bit rnd);
        int r      = 10;
        int stalls = 0;
        int guard  = 0;
        bit rdy;
        cyc_cnt = 1;
        while (r >= 0) begin
            if (guard > 200) begin
                nvec++;
                nerr++;
                $display("FAIL drain_timeout: stuck at round %0d expected progress", r);
                return;
            end
            chk("rk_valid", 128'(bus.rk_valid), 128'(1));
            chk("busy",     128'(bus.busy),     128'(1));
            chk("rk_round", 128'(bus.rk_round), 128'(r));
            chk("rk",       bus.rk,             exp_key(ref_rk[r], r));
            got_rk[r] = bus.rk;
            rdy = 1'b1;
            if (r == stall_r && stalls < stall_n) begin
                rdy = 1'b0;
                stalls++;
            end else if (rnd && $urandom_range(3) == 0) begin
                rdy = 1'b0;
            end
            bus.rk_ready = rdy;
            if (r == glitch_r) begin
                bus.ld     = 1'b1;
                bus.key_in = ~bus.key_in;
            end
            step();
            bus.ld = 1'b0;
            cyc_cnt++;
            guard++;
            if (rdy) r--;
        end
        chk("done",        128'(bus.done),     128'(1));
        chk("end_valid",   128'(bus.rk_valid), 128'(0));
        chk("end_busy",    128'(bus.busy),     128'(0));
        chk("end_round",   128'(bus.rk_round), 128'(0));
        chk("end_rk_hold", bus.rk,             exp_key(ref_rk[0], 0));
        bus.rk_ready = 1'b1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- test ----------------
    initial begin
        int g;
        logic [127:0] kb;

        tbl[0] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[1] = '{9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[2] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[3] = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        clk          = 1'b0;
        rst          = 1'b0;
        bus.ld       = 1'b0;
        bus.key_in   = '0;
        bus.rk_ready = 1'b0;
        build_sbox();

        // reset state
        #3;
        chk("rst_rk",       bus.rk,                  128'h0);
        chk("rst_rk_round", 128'(bus.rk_round),      128'(0));
        chk("rst_valid",    128'(bus.rk_valid),      128'(0));
        chk("rst_busy",     128'(bus.busy),          128'(0));
        chk("rst_done",     128'(bus.done),          128'(0));
        #9 rst = 1'b1;
        step();
        bus.rk_ready = 1'b1;

        // FIPS-197 vector, ready always high
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        ld_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        drain(-1, 0, -1, 1'b0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fips_rk%0d", tbl[i].rnd), got_rk[tbl[i].rnd],
                exp_key(tbl[i].raw, tbl[i].rnd));
        chk("fips_done_cycle", 128'(cyc_cnt), 128'(12));
        step();
        chk("done_pulse_len", 128'(bus.done), 128'(0));

        // Backpressure: 3 stall cycles at round 7
        expand(rnd128());
        ld_key(ref_rk[10]);
        drain(7, 3, -1, 1'b0);
        chk("bp_done_cycle", 128'(cyc_cnt), 128'(15));
        step();

        // ld with another key at round 5 is ignored
        expand(rnd128());
        ld_key(ref_rk[10]);
        drain(-1, 0, 5, 1'b0);
        step();

        // Async reset at round 4, then restart
        expand(rnd128());
        ld_key(ref_rk[10]);
        g = 0;
        while (bus.rk_round != 4'd4 && g < 50) begin
            step();
            g++;
        end
        chk("reach_round4", 128'(bus.rk_round), 128'(4));
        rst = 1'b0;
        #1;
        chk("arst_rk",       bus.rk,             128'h0);
        chk("arst_rk_round", 128'(bus.rk_round), 128'(0));
        chk("arst_valid",    128'(bus.rk_valid), 128'(0));
        chk("arst_busy",     128'(bus.busy),     128'(0));
        chk("arst_done",     128'(bus.done),     128'(0));
        #1 rst = 1'b1;
        step();
        chk("post_rst_idle", 128'(bus.rk_valid), 128'(0));
        ld_key(ref_rk[10]);
        drain(-1, 0, -1, 1'b0);
        step();

        // ld in the done cycle is accepted
        expand(rnd128());
        ld_key(ref_rk[10]);
        drain(-1, 0, -1, 1'b0);
        kb = rnd128();
        expand(kb);
        ld_key(ref_rk[10]);
        drain(-1, 0, -1, 1'b0);
        step();

        // Random keys with random backpressure
        for (int n = 0; n < 6; n++) begin
            expand(rnd128());
            ld_key(ref_rk[10]);
            drain(-1, 0, -1, 1'b1);
            step();
            chk("rand_idle_done", 128'(bus.done), 128'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_expand_128.md
# aes_inv_key_expand_128

Backward AES-128 key schedule. It takes the final (round-10) round key and produces round keys 10 down to 0, one per handshake beat. It sits beside `aes_inv_cipher_top` and feeds the decryption datapath without storing all 11 round keys. It reuses the existing combinational `aes_sbox` (four instances) for SubWord.

## Interface
Parameters: none.

- `clk`  in  1  — single clock domain; all state updates on rising edge.
- `rst`  in  1  — asynchronous reset, active-low.
- `ld`  in  1  — start request; sampled only in IDLE.
- `key_in`  in  128  — round-10 key; sampled on an accepted `ld`. Word 0 is `[127:96]`.
- `rk`  out  128  — current round key. Same word order as `key_in`.
- `rk_round`  out  4  — round index of `rk`, 10..0.
- `rk_valid`  out  1  — `rk` and `rk_round` are valid.
- `rk_ready`  in  1  — consumer accepts the key; a transfer is `rk_valid && rk_ready`.
- `busy`  out  1  — high in RUN.
- `done`  out  1  — one-cycle pulse after round 0 is transferred.

## Operation
- States: IDLE and RUN.
- Reset (`rst` low, asynchronous):
  - state goes to IDLE;
  - `rk` = 0, `rk_round` = 0, `rk_valid` = 0, `busy` = 0, `done` = 0.
- IDLE with `ld` high at an edge:
  - key register ← `key_in`, round ← 10;
  - `rk_valid` ← 1, `busy` ← 1, state ← RUN.
- IDLE with `ld` low: no change.
- RUN, transfer at an edge with round r > 0: register ← prev(k), round ← r−1. Here prev of `k` = {k0,k1,k2,k3} is:
  - p3 = k3 ^ k2, p2 = k2 ^ k1, p1 = k1 ^ k0;
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0};
  - RotWord({a,b,c,d}) = {b,c,d,a};
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- RUN, transfer with round 0:
  - `rk_valid` ← 0, `busy` ← 0, `done` ← 1 for one cycle, state ← IDLE;
  - `rk` and `rk_round` hold their last value.
- RUN, no transfer (`rk_ready` low): all outputs hold, so `rk` is stable while stalled.
- `ld` during RUN is ignored and does not restart the sequence.
- `ld` in the same cycle `done` is high is legal: the block is already in IDLE and accepts it.
- `rst` low mid-sequence aborts immediately. Restarting needs a fresh `ld`.
- Rcon is a 4-bit-indexed case. Rounds 0 and 11..15 select 0; those indices are unreachable.

## Timing
- Latency from accepted `ld` to first `rk_valid`: 1 cycle.
- Throughput with `rk_ready` held high: one key per cycle. The 11 keys occupy cycles 1..11 after `ld`, and `done` is high in cycle 12.
- Next-key logic is combinational from the key register and is registered on transfer. The critical path is the sbox plus two XOR levels.
- `rk_valid` never drops without a transfer, and `rk` never changes while `rk_valid && !rk_ready`.

## Configuration
- `AES_INV_KEY_EQINV_EN` defined (key-format option for the equivalent inverse cipher):
  - `rk` for rounds 9..1 is InvMixColumns applied to the internal key, column-wise over the four 32-bit words, using GF(2^8) multiplies by 0e/0b/0d/09;
  - rounds 10 and 0 are output raw;
  - the output path is registered alongside the key register, so latency and handshake are unchanged.
- Undefined: `rk` is always the raw round key and no InvMixColumns logic is present.
- In both cases the internal backward recursion always operates on raw keys.

## Test plan
- FIPS-197 vector, `rk_ready` always 1; `ld` with `key_in` = d014f9a8c9ee2589e13f0cc8b6630ca6 ->
  - round 10 key equals `key_in` one cycle after `ld`;
  - round 9 = ac7766f319fadc2128d12941575c006e;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c;
  - `done` high in cycle 12.
- Backpressure: drop `rk_ready` for 3 cycles at round 7 -> `rk` and `rk_round` = 7 hold unchanged; the sequence resumes at round 6 with no key skipped or repeated.
- `ld` pulsed with a different key at round 5 -> ignored; the remaining keys follow the original schedule.
- `rst` low at round 4 -> all outputs 0 asynchronously; the next `ld` restarts at round 10 with correct keys.
- `ld` asserted in the `done` cycle -> accepted; round 10 of the new key is valid on the next cycle.
- With `AES_INV_KEY_EQINV_EN`, same FIPS vector -> rounds 9..1 equal InvMixColumns of the reference keys; rounds 10 and 0 are raw.
